// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: datapath width and operation encodings.
package alu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SLL   = 4'b0001,
        ALU_SLT   = 4'b0010,
        ALU_SLTU  = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SRL   = 4'b0101,
        ALU_OR    = 4'b0110,
        ALU_AND   = 4'b0111,
        ALU_SUB   = 4'b1000,
        ALU_SRA   = 4'b1101,
        ALU_PASSB = 4'b1111
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } muldiv_op_e;

endpackage

// File: rtl/alu_muldiv.sv
// Combinational RV32M multiply/divide unit, including divide-by-zero and signed-overflow results.
module alu_muldiv
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  muldiv_op_e      op,
    output logic [XLEN-1:0] result
);

    logic            sign_a;
    logic            sign_b;
    logic [63:0]     a_ext;
    logic [63:0]     b_ext;
    logic [63:0]     prod;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] divisor_u;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] q_mag;
    logic [XLEN-1:0] r_mag;
    logic [XLEN-1:0] q_u;
    logic [XLEN-1:0] r_u;

    // Low 64 bits of a mixed-sign product are exact when each operand is extended per its signedness.
    always_comb begin
        sign_a = (op == MD_MULH) || (op == MD_MULHSU);
        sign_b = (op == MD_MULH);
        a_ext  = {{32{sign_a & rs1[31]}}, rs1};
        b_ext  = {{32{sign_b & rs2[31]}}, rs2};
        prod   = a_ext * b_ext;
    end

    // Divisor is forced non-zero so the dividers never see /0; the zero case is selected below.
    always_comb begin
        div_zero  = (rs2 == '0);
        overflow  = (rs1 == 32'h8000_0000) && (rs2 == '1);
        divisor_u = div_zero ? 32'd1 : rs2;
        a_mag     = rs1[31] ? (32'd0 - rs1) : rs1;
        b_mag     = rs2[31] ? (32'd0 - rs2) : divisor_u;
        q_mag     = a_mag / b_mag;
        r_mag     = a_mag % b_mag;
        q_u       = rs1 / divisor_u;
        r_u       = rs1 % divisor_u;
    end

    always_comb begin
        result = '0;
        case (op)
            MD_MUL:    result = prod[31:0];
            MD_MULH,
            MD_MULHSU,
            MD_MULHU:  result = prod[63:32];
            MD_DIV: begin
                if (div_zero)
                    result = '1;
                else if (overflow)
                    result = 32'h8000_0000;
                else
                    result = (rs1[31] ^ rs2[31]) ? (32'd0 - q_mag) : q_mag;
            end
            MD_DIVU:   result = div_zero ? '1 : q_u;
            MD_REM: begin
                if (div_zero)
                    result = rs1;
                else if (overflow)
                    result = '0;
                else
                    result = rs1[31] ? (32'd0 - r_mag) : r_mag;
            end
            MD_REMU:   result = div_zero ? rs1 : r_u;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// RV32I/RV32M execute-stage ALU: combinational result plus a one-cycle registered copy.
module alu
    import alu_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [3:0]      AluSel_i,
    input  logic            Mul_ext_i,
    output logic [XLEN-1:0] Result_o,
    output logic [XLEN-1:0] Result_q_o
);

    logic [4:0]      shamt;
    logic [XLEN-1:0] base_result;
    logic [XLEN-1:0] md_result;

    assign shamt = rs2_i[4:0];

    always_comb begin
        base_result = '0;
        case (AluSel_i)
            ALU_ADD:   base_result = rs1_i + rs2_i;
            ALU_SUB:   base_result = rs1_i - rs2_i;
            ALU_SLL:   base_result = rs1_i << shamt;
            ALU_SLT:   base_result = {31'd0, $signed(rs1_i) < $signed(rs2_i)};
            ALU_SLTU:  base_result = {31'd0, rs1_i < rs2_i};
            ALU_XOR:   base_result = rs1_i ^ rs2_i;
            ALU_SRL:   base_result = rs1_i >> shamt;
            ALU_SRA:   base_result = $unsigned($signed(rs1_i) >>> shamt);
            ALU_OR:    base_result = rs1_i | rs2_i;
            ALU_AND:   base_result = rs1_i & rs2_i;
            ALU_PASSB: base_result = rs2_i;
            default:   base_result = '0;
        endcase
    end

    alu_muldiv u_muldiv (
        .rs1    (rs1_i),
        .rs2    (rs2_i),
        .op     (muldiv_op_e'(AluSel_i[2:0])),
        .result (md_result)
    );

    assign Result_o = Mul_ext_i ? md_result : base_result;

    always_ff @(posedge clk_i) begin
        if (rst_ni)
            Result_q_o <= '0;
        else
            Result_q_o <= Result_o;
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; expected values are queued at drive time and popped at sampling.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  sel;
    logic        mext;
    logic [31:0] res;
    logic [31:0] res_q;

    int unsigned checks;
    int unsigned errors;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];

    alu dut (
        .clk_i      (clk),
        .rst_ni     (rst),
        .rs1_i      (rs1),
        .rs2_i      (rs2),
        .AluSel_i   (sel),
        .Mul_ext_i  (mext),
        .Result_o   (res),
        .Result_q_o (res_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input logic [31:0] obs);
        sb_entry_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic apply(input string tag, input logic m, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        mext = m;
        sel  = s;
        rs1  = a;
        rs2  = b;
        sb.push_back('{tag, exp});
        #1;
        check(res);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b1;
        mext = 1'b0;
        sel  = 4'b0000;
        rs1  = 32'd0;
        rs2  = 32'd0;

        // Registered output under reset
        repeat (2) @(posedge clk);
        #1;
        sb.push_back('{"reset_q", 32'd0});
        check(res_q);

        // Release reset, add 2 + 3: immediate combinational then registered after one edge
        @(negedge clk);
        rst = 1'b0;
        sel = 4'b0000; mext = 1'b0; rs1 = 32'd2; rs2 = 32'd3;
        sb.push_back('{"add_comb", 32'd5});
        sb.push_back('{"add_q", 32'd5});
        #1;
        check(res);
        @(posedge clk);
        #1;
        check(res_q);

        // Mid-stream reset clears the register but not the combinational result
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{"midreset_q", 32'd0});
        sb.push_back('{"midreset_comb", 32'd5});
        check(res_q);
        check(res);
        @(negedge clk);
        rst = 1'b0;

        apply("add_ovf",  1'b0, 4'b0000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
        apply("add_wrap", 1'b0, 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000);
        apply("sub",      1'b0, 4'b1000, 32'd5, 32'd7, 32'hFFFF_FFFE);
        apply("sll",      1'b0, 4'b0001, 32'h8000_00F0, 32'h0000_0024, 32'h0000_0F00);
        apply("srl",      1'b0, 4'b0101, 32'h8000_00F0, 32'h0000_0024, 32'h0800_000F);
        apply("sra",      1'b0, 4'b1101, 32'h8000_00F0, 32'h0000_0024, 32'hF800_000F);
        apply("sra_zero", 1'b0, 4'b1101, 32'h8000_00F0, 32'hFFFF_FFE0, 32'h8000_00F0);
        apply("slt",      1'b0, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd1);
        apply("sltu",     1'b0, 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0);
        apply("xor",      1'b0, 4'b0100, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB);
        apply("or",       1'b0, 4'b0110, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF);
        apply("and",      1'b0, 4'b0111, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234);
        apply("passb",    1'b0, 4'b1111, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0FF0_FFFF);
        apply("unused_a", 1'b0, 4'b1010, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0000_0000);
        apply("unused_e", 1'b0, 4'b1110, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0000_0000);

        apply("mul",        1'b1, 4'b0000, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
        apply("mul_bit3",   1'b1, 4'b1000, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
        apply("mulh",       1'b1, 4'b0001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        apply("mulhsu",     1'b1, 4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        apply("mulhu",      1'b1, 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        apply("div",        1'b1, 4'b0100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        apply("rem",        1'b1, 4'b0110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        apply("divu",       1'b1, 4'b0101, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF);
        apply("remu",       1'b1, 4'b0111, 32'd10, 32'd3, 32'd1);
        apply("div_zero",   1'b1, 4'b0100, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        apply("divu_zero",  1'b1, 4'b0101, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        apply("rem_zero",   1'b1, 4'b0110, 32'd9, 32'd0, 32'd9);
        apply("remu_zero",  1'b1, 4'b0111, 32'd7, 32'd0, 32'd7);
        apply("div_ovf",    1'b1, 4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        apply("rem_ovf",    1'b1, 4'b0110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

        // Registered copy tracks the last combinational result after one edge
        @(posedge clk);
        #1;
        sb.push_back('{"last_q", 32'h0000_0000});
        check(res_q);
        apply("mul_last",   1'b1, 4'b0000, 32'd6, 32'd7, 32'd42);
        @(posedge clk);
        #1;
        sb.push_back('{"mul_last_q", 32'd42});
        check(res_q);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for the single-cycle RV32I core, with optional RV32M multiply/divide operations.
- Sits in the execute stage. Operands come from the register file or immediate mux; the opcode comes from the control decoder.
- The result is combinational, so the core can use it in the same cycle.
- A registered copy of the result is also provided for debug and pipelining use.

Parameters:
- XLEN, 32, datapath width. Only 32 is required to be supported.

Ports:
- clk_i  input  1  system clock; rising edge active.
- rst_ni  input  1  synchronous, active-high reset (asserted = 1), sampled on the rising edge of clk_i.
- rs1_i  input  32  operand A.
- rs2_i  input  32  operand B; bits [4:0] are the shift amount.
- AluSel_i  input  4  operation select.
- Mul_ext_i  input  1  1 = RV32M operation group; 0 = base RV32I group.
- Result_o  output  32  combinational result.
- Result_q_o  output  32  Result_o registered on clk_i.

Behaviour:
- Result_o is purely combinational from rs1_i, rs2_i, AluSel_i and Mul_ext_i. Zero latency; it is valid in the same delta cycle the inputs settle. It is independent of clk_i and rst_ni.
- Base group (Mul_ext_i = 0), by AluSel_i:
  - 0000 add: rs1 + rs2, mod 2^32, carry discarded.
  - 1000 sub: rs1 - rs2, mod 2^32.
  - 0001 sll: rs1 << rs2[4:0].
  - 0010 slt: 1 if signed(rs1) < signed(rs2), else 0.
  - 0011 sltu: 1 if unsigned(rs1) < unsigned(rs2), else 0.
  - 0100 xor: rs1 ^ rs2.
  - 0101 srl: logical shift right by rs2[4:0].
  - 1101 sra: arithmetic shift right by rs2[4:0], sign-filled.
  - 0110 or: rs1 | rs2.
  - 0111 and: rs1 & rs2.
  - 1111 pass B: rs2.
  - 1001, 1010, 1011, 1100, 1110: result 0.
- Shift amounts use only rs2[4:0]; rs2[31:5] is ignored. A shift amount of 0 returns rs1 unchanged.
- Compare results are zero-extended to 32 bits: 32'h0000_0001 or 32'h0.
- M group (Mul_ext_i = 1): AluSel_i[2:0] is the funct3; AluSel_i[3] is ignored.
  - 000 mul: low 32 bits of the product.
  - 001 mulh: high 32 bits of signed × signed.
  - 010 mulhsu: high 32 bits of signed(rs1) × unsigned(rs2).
  - 011 mulhu: high 32 bits of unsigned × unsigned.
  - 100 div: signed quotient, truncated toward zero.
  - 101 divu: unsigned quotient.
  - 110 rem: signed remainder; its sign follows the dividend.
  - 111 remu: unsigned remainder.
- Divide by zero (rs2 = 0):
  - div and divu return 32'hFFFF_FFFF.
  - rem and remu return rs1.
- Signed overflow (rs1 = 32'h8000_0000, rs2 = 32'hFFFF_FFFF):
  - div returns 32'h8000_0000.
  - rem returns 0.
- No X-propagation from unused codes: every case has a defined default.
- Result_q_o:
  - On a rising edge with rst_ni = 1, Result_q_o <= 0.
  - Otherwise Result_q_o <= Result_o.
  - Reset value is 0; latency is 1 cycle. A reset asserted mid-stream clears it on the next edge only; Result_o is unaffected.
- No handshake and no internal state other than Result_q_o.

Decomposition:
- Shared package alu_pkg:
  - enum alu_op_e with ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB, using the 4-bit codes above.
  - enum muldiv_op_e with the 3-bit funct3 codes.
  - constant XLEN.
- One sub-module, alu_muldiv: combinational RV32M unit, including the divide-by-zero and overflow special cases. The top level muxes between the base result and the alu_muldiv result on Mul_ext_i.

Test Plan:
- Arithmetic:
  - add 32'h7FFF_FFFF + 1 -> 32'h8000_0000.
  - add 32'hFFFF_FFFF + 1 -> 0.
  - sub 5 - 7 -> 32'hFFFF_FFFE.
- Shifts, rs1 = 32'h8000_00F0, rs2 = 32'h0000_0024 (amount 4):
  - sll -> 32'h0000_0F00.
  - srl -> 32'h0800_000F.
  - sra -> 32'hF800_000F.
- Compares, rs1 = 32'hFFFF_FFFF, rs2 = 1:
  - slt -> 1.
  - sltu -> 0.
- Logic and pass-B, rs1 = 32'hF0F0_1234, rs2 = 32'h0FF0_FFFF:
  - xor -> 32'hFF00_EDCB.
  - or -> 32'hFFF0_FFFF.
  - and -> 32'h00F0_1234.
  - code 1111 -> 32'h0FF0_FFFF.
  - code 1010 -> 0.
- M group:
  - mul 32'hFFFF_FFFF × 3 -> 32'hFFFF_FFFD.
  - mulhu 32'hFFFF_FFFF × 32'hFFFF_FFFF -> 32'hFFFF_FFFE.
  - div -7 / 2 -> 32'hFFFF_FFFD.
  - rem -7 % 2 -> 32'hFFFF_FFFF.
  - div x / 0 -> 32'hFFFF_FFFF.
  - rem 9 % 0 -> 9.
  - div 32'h8000_0000 / -1 -> 32'h8000_0000.
- Registered output: hold rst_ni = 1 for 2 edges -> Result_q_o = 0; release reset, apply add 2 + 3 -> Result_o = 5 immediately, Result_q_o = 5 after the next rising edge.
